c1_sub_serial: RTL and testbench

//  Bit-serial one's complement (C1) subtractor: z = x - y, computed as x + ~y with end-around carry.

---
 rtl/c1_sub_serial.sv | 102 ++++++++++
 tb/tb_c1_sub_serial.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/c1_sub_serial.sv
// c1_sub_serial: bit-serial one's complement subtractor z = x + ~y with end-around carry, one full adder reused over 2*W cycles
module c1_sub_serial #(
  parameter int W = 4,
  parameter bit NORM_ZERO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         ovf,
  output logic         is_zero
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, t_q, t_d, z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, sx_q, sx_d, sy_q, sy_d, ovf_q, ovf_d, iz_q, iz_d;
  logic fa_a, fa_b, fa_s, fa_c, last, accept, run;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    t_d = t_q;
    c_d = c_q;
    cnt_d = cnt_q;
    sx_d = sx_q;
    sy_d = sy_q;
    z_d = z_q;
    ovf_d = ovf_q;
    iz_d = iz_q;
    accept = start && (state_q == IDLE || state_q == DONE);
    run = state_q == PASS1 || state_q == PASS2;
    last = cnt_q == CW'(W - 1);
    // PASS2 feeds the partial sum back with b forced to 0 so the carry left by PASS1 is added once
    fa_a = (state_q == PASS1) ? a_q[0] : t_q[0];
    fa_b = (state_q == PASS1) && b_q[0];
    fa_s = fa_a ^ fa_b ^ c_q;
    fa_c = (fa_a & fa_b) | (c_q & (fa_a ^ fa_b));
    if (run) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      t_d = {fa_s, t_q[W-1:1]};
      c_d = fa_c;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) state_d = (state_q == PASS1) ? PASS2 : DONE;
    end
    if (run && last && state_q == PASS2) begin
      c_d = 1'b0;
      z_d = (NORM_ZERO && &t_d) ? '0 : t_d;
      iz_d = ~|t_d || &t_d;
      ovf_d = (sx_q != sy_q) && (t_d[W-1] != sx_q);
    end
    if (state_q == DONE) state_d = IDLE;
    if (accept) begin
      a_d = x;
      b_d = ~y;
      sx_d = x[W-1];
      sy_d = y[W-1];
      c_d = 1'b0;
      cnt_d = '0;
      t_d = '0;
      state_d = PASS1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      t_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
      z_q <= '0;
      ovf_q <= 1'b0;
      iz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      t_q <= t_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      z_q <= z_d;
      ovf_q <= ovf_d;
      iz_q <= iz_d;
    end
  end
  assign busy = state_q == PASS1 || state_q == PASS2;
  assign done = state_q == DONE;
  assign z = z_q;
  assign ovf = ovf_q;
  assign is_zero = iz_q;
endmodule

// File: tb/tb_c1_sub_serial.sv
// tb_c1_sub_serial: randomized and directed checks of c1_sub_serial against an arithmetic C1 reference model
module tb_c1_sub_serial;
  logic clk = 1'b0, rst = 1'b1, start4 = 1'b0, start8 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0, z0, z1;
  logic [7:0] x8 = '0, y8 = '0, z2;
  logic busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2, iz0, iz1, iz2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  c1_sub_serial #(.W(4), .NORM_ZERO(1'b0)) u0 (.clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .busy(busy0), .done(done0), .z(z0), .ovf(ovf0), .is_zero(iz0));
  c1_sub_serial #(.W(4), .NORM_ZERO(1'b1)) u1 (.clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
    .busy(busy1), .done(done1), .z(z1), .ovf(ovf1), .is_zero(iz1));
  c1_sub_serial #(.W(8), .NORM_ZERO(1'b0)) u2 (.clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
    .busy(busy2), .done(done2), .z(z2), .ovf(ovf2), .is_zero(iz2));
  function automatic int c1v(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return ((v >> (w - 1)) & 1) != 0 ? -((~v) & m) : v;
  endfunction
  // end-around-carry sum for the bit pattern; overflow from the true signed difference
  function automatic void ref_sub(input int w, input bit norm, input int xv, input int yv,
                                  output int rz, output bit rov, output bit riz);
    int m, s, r, d;
    m = (1 << w) - 1;
    s = xv + ((~yv) & m);
    r = (s & m) + (s >> w);
    riz = (r == 0) || (r == m);
    rz = (norm && r == m) ? 0 : r;
    d = c1v(xv, w) - c1v(yv, w);
    rov = (d > (m >> 1)) || (d < -(m >> 1));
  endfunction
  task automatic op4(input logic [3:0] xa, input logic [3:0] ya, output int lat, output logic bz);
    start4 = 1'b1; x4 = xa; y4 = ya;
    @(posedge clk); #1;
    start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom); bz = busy0; lat = 0;
    while (!done0 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic op8(input logic [7:0] xa, input logic [7:0] ya, output int lat, output logic bz);
    start8 = 1'b1; x8 = xa; y8 = ya;
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); bz = busy2; lat = 0;
    while (!done2 && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if ({z0, ovf0, iz0, busy0, done0} !== 8'h0) begin n_bad++; $display("FAIL reset_u0 got %b required 0", {z0, ovf0, iz0, busy0, done0}); end
    n_cmp++; if ({z1, ovf1, iz1, busy1, done1} !== 8'h0) begin n_bad++; $display("FAIL reset_u1 got %b required 0", {z1, ovf1, iz1, busy1, done1}); end
    n_cmp++; if ({z2, ovf2, iz2, busy2, done2} !== 12'h0) begin n_bad++; $display("FAIL reset_u2 got %b required 0", {z2, ovf2, iz2, busy2, done2}); end
  endtask
  task automatic test_directed();
    logic [3:0] dx[5] = '{4'b0101, 4'b0011, 4'b0101, 4'b0111, 4'b1000};
    logic [3:0] dy[5] = '{4'b0011, 4'b0101, 4'b0101, 4'b1000, 4'b0111};
    logic [3:0] ez0[5] = '{4'b0010, 4'b1101, 4'b1111, 4'b1110, 4'b0001};
    logic [3:0] ez1[5] = '{4'b0010, 4'b1101, 4'b0000, 4'b1110, 4'b0001};
    logic eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ei[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic bz;
    for (int i = 0; i < 5; i++) begin
      op4(dx[i], dy[i], lat, bz);
      n_cmp++; if (lat + 1 !== 9 || bz !== 1'b1) begin n_bad++; $display("FAIL dir_latency case %0d got %0d cycles busy=%b required 9 cycles busy=1", i, lat + 1, bz); end
      n_cmp++; if ({z0, ovf0, iz0} !== {ez0[i], eo[i], ei[i]}) begin n_bad++; $display("FAIL dir_n0 case %0d got z=%b ovf=%b iz=%b required z=%b ovf=%b iz=%b", i, z0, ovf0, iz0, ez0[i], eo[i], ei[i]); end
      n_cmp++; if ({z1, ovf1, iz1} !== {ez1[i], eo[i], ei[i]}) begin n_bad++; $display("FAIL dir_n1 case %0d got z=%b ovf=%b iz=%b required z=%b ovf=%b iz=%b", i, z1, ovf1, iz1, ez1[i], eo[i], ei[i]); end
    end
  endtask
  task automatic test_ignore_start();
    int lat;
    @(posedge clk); #1;
    start4 = 1'b1; x4 = 4'b0101; y4 = 4'b0011;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start4 = 1'b1; x4 = 4'b0011; y4 = 4'b0101;
    @(posedge clk); #1;
    start4 = 1'b0; lat = 3;
    while (!done0 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL ignore_latency got %0d cycles required 9", lat + 1); end
    n_cmp++; if ({z0, ovf0, iz0} !== {4'b0010, 1'b0, 1'b0}) begin n_bad++; $display("FAIL ignore_result got z=%b ovf=%b iz=%b required z=0010 ovf=0 iz=0", z0, ovf0, iz0); end
  endtask
  task automatic test_back_to_back();
    int lat;
    logic bz;
    op4(4'b0011, 4'b0101, lat, bz);
    op4(4'b1000, 4'b0111, lat, bz);
    n_cmp++; if (bz !== 1'b1 || lat !== 8) begin n_bad++; $display("FAIL b2b_accept got busy=%b cycles=%0d required busy=1 cycles=9", bz, lat + 1); end
    n_cmp++; if ({z0, ovf0} !== {4'b0001, 1'b1}) begin n_bad++; $display("FAIL b2b_result got z=%b ovf=%b required z=0001 ovf=1", z0, ovf0); end
    @(posedge clk); #1;
    n_cmp++; if ({done0, busy0, z0, ovf0} !== {2'b00, 4'b0001, 1'b1}) begin n_bad++; $display("FAIL b2b_hold got done=%b busy=%b z=%b ovf=%b required done=0 busy=0 z=0001 ovf=1", done0, busy0, z0, ovf0); end
  endtask
  task automatic test_reset_mid();
    logic seen;
    start4 = 1'b1; x4 = 4'b0101; y4 = 4'b0011;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({z0, ovf0, iz0, busy0, done0} !== 8'h0) begin n_bad++; $display("FAIL rst_mid_outputs got %b required 0", {z0, ovf0, iz0, busy0, done0}); end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen = seen | done0 | busy0 | (|z0); end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_quiet got activity=%b required 0", seen); end
  endtask
  task automatic test_exhaustive4();
    int lat, rz0, rz1;
    logic bz;
    bit rov, riz, rov1, riz1;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op4(4'(i >> 4), 4'(i), lat, bz);
      ref_sub(4, 1'b0, i >> 4, i & 15, rz0, rov, riz);
      ref_sub(4, 1'b1, i >> 4, i & 15, rz1, rov1, riz1);
      n_cmp++; if (lat !== 8 || bz !== 1'b1) begin n_bad++; $display("FAIL exh4_latency x=%h y=%h got %0d cycles busy=%b required 9 busy=1", i >> 4, i & 15, lat + 1, bz); end
      n_cmp++; if ({z0, ovf0, iz0} !== {4'(rz0), rov, riz}) begin n_bad++; $display("FAIL exh4_n0 x=%h y=%h got z=%b ovf=%b iz=%b required z=%b ovf=%b iz=%b", i >> 4, i & 15, z0, ovf0, iz0, 4'(rz0), rov, riz); end
      n_cmp++; if ({z1, ovf1, iz1} !== {4'(rz1), rov1, riz1}) begin n_bad++; $display("FAIL exh4_n1 x=%h y=%h got z=%b ovf=%b iz=%b required z=%b ovf=%b iz=%b", i >> 4, i & 15, z1, ovf1, iz1, 4'(rz1), rov1, riz1); end
    end
  endtask
  task automatic test_random8();
    int lat, rz, xv, yv;
    logic bz;
    bit rov, riz;
    for (int i = 0; i < 200; i++) begin
      xv = (i < 4) ? ((i & 1) != 0 ? 255 : 0) : int'($urandom_range(0, 255));
      yv = (i < 4) ? ((i & 2) != 0 ? 255 : 0) : int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op8(8'(xv), 8'(yv), lat, bz);
      ref_sub(8, 1'b0, xv, yv, rz, rov, riz);
      n_cmp++; if (lat !== 16 || bz !== 1'b1) begin n_bad++; $display("FAIL rnd8_latency x=%h y=%h got %0d cycles busy=%b required 17 busy=1", xv, yv, lat + 1, bz); end
      n_cmp++; if ({z2, ovf2, iz2} !== {8'(rz), rov, riz}) begin n_bad++; $display("FAIL rnd8 x=%h y=%h got z=%h ovf=%b iz=%b required z=%h ovf=%b iz=%b", xv, yv, z2, ovf2, iz2, 8'(rz), rov, riz); end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_ignore_start();
    test_exhaustive4();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
